// File: rtl/harness_proto_pkg.sv
// Shared definitions for the simulation-harness command protocol.
//  - Command byte values sent on the byte channel
//  - Request op codes (3-bit) offered by the test sequencer
//  - Driver FSM state encoding
//  - op_to_cmd: maps a request op to its leading command byte
package harness_proto_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_SAMPLE  = 8'd104;
  localparam logic [BYTE_W-1:0] CMD_FINISH  = 8'd105;
  localparam logic [BYTE_W-1:0] CMD_RST_ON  = 8'd106;
  localparam logic [BYTE_W-1:0] CMD_RST_OFF = 8'd107;
  localparam logic [BYTE_W-1:0] CMD_STEP    = 8'd108;
  localparam logic [BYTE_W-1:0] CMD_LOAD    = 8'd109;

  typedef enum logic [OP_W-1:0] {
    OP_RST_ON  = 3'd0,
    OP_RST_OFF = 3'd1,
    OP_STEP    = 3'd2,
    OP_LOAD    = 3'd3,
    OP_SAMPLE  = 3'd4,
    OP_FINISH  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_STEP      = 3'd3,
    ST_WAIT_RSP  = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Leading command byte for an op; unknown codes map to 0 and are
  // otherwise treated like a plain single-byte command.
  function automatic logic [BYTE_W-1:0] op_to_cmd(input op_e op);
    logic [BYTE_W-1:0] cmd;
    cmd = 8'd0;
    case (op)
      OP_RST_ON:  cmd = CMD_RST_ON;
      OP_RST_OFF: cmd = CMD_RST_OFF;
      OP_STEP:    cmd = CMD_STEP;
      OP_LOAD:    cmd = CMD_LOAD;
      OP_SAMPLE:  cmd = CMD_SAMPLE;
      OP_FINISH:  cmd = CMD_FINISH;
      default:    cmd = 8'd0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/harness_rsp_assembler.sv
// Reassembles sampled-output reply bytes into an OUTPUT_SIZE vector.
// Bytes arrive word 0 first, little-endian within each word, so overall
// byte k lands on bits [8k+7:8k]; bits at or above OUTPUT_SIZE are dropped.
// Ports:
//  clk, rst      clock, asynchronous active-low reset
//  byte_valid_i  a reply byte is being accepted this cycle
//  byte_i        reply byte
//  clear_i       abandon a partial reply (counter back to byte 0)
//  done_c        combinational: this byte completes the reply
//  vec_c         combinational: assembled vector including this byte
module harness_rsp_assembler
  import harness_proto_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_valid_i,
  input  logic [BYTE_W-1:0]      byte_i,
  input  logic                   clear_i,
  output logic                   done_c,
  output logic [OUTPUT_SIZE-1:0] vec_c
);

  localparam int unsigned OUTPUT_WORDS = (OUTPUT_SIZE + 31) / 32;
  localparam int unsigned NBYTES       = OUTPUT_WORDS * 4;
  localparam int unsigned CNT_W        = $clog2(NBYTES);
  localparam int unsigned IDX_W        = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUTPUT_SIZE-1:0] buf_q, buf_d;

  // Byte placement and reply-length counting.
  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    done_c = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      for (int unsigned b = 0; b < BYTE_W; b++) begin
        if (32'(cnt_q) * 32'd8 + b < OUTPUT_SIZE) begin
          buf_d[IDX_W'(32'(cnt_q) * 32'd8 + b)] = byte_i[3'(b)];
        end
      end
      if (cnt_q == CNT_W'(NBYTES - 1)) begin
        cnt_d  = '0;
        done_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign vec_c = buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/harness_cmd_driver.sv
// Host-side driver for the byte-oriented simulation-harness command protocol.
// Turns sequencer requests into command byte streams and reassembles
// sampled-output replies.
// Ports:
//  clk, rst                         clock, asynchronous active-low reset
//  req_valid/req_ready              request handshake
//  req_op, req_data, req_count      op code, LOAD payload, STEP period count
//  tx_valid/tx_ready/tx_data        outgoing command byte stream
//  rx_valid/rx_ready/rx_data        incoming reply byte stream
//  rsp_valid, rsp_data              one-cycle pulse with a complete sample
//  err                              sticky protocol error (reset clears)
// Build option: define HARNESS_DRV_TIMEOUT_EN to add a reply watchdog of
// TIMEOUT_CYCLES idle cycles in WAIT_RSP.
module harness_cmd_driver
  import harness_proto_pkg::*;
#(
  parameter int unsigned INPUT_SIZE     = 32,
  parameter int unsigned OUTPUT_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OP_W-1:0]        req_op,
  input  logic [INPUT_SIZE-1:0]  req_data,
  input  logic [15:0]            req_count,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [BYTE_W-1:0]      rx_data,
  output logic                   rsp_valid,
  output logic [OUTPUT_SIZE-1:0] rsp_data,
  output logic                   err
);

  localparam int unsigned INPUT_BYTES = (INPUT_SIZE + 7) / 8;
  localparam int unsigned DATA_W      = INPUT_BYTES * 8;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [15:0]            count_q, count_d;
  logic                   req_ready_q, req_ready_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]      tx_data_q, tx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [OUTPUT_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic                   tx_hs_c, rx_hs_c;
  logic                   asm_valid_c, asm_clear_c, asm_done_c;
  logic [OUTPUT_SIZE-1:0] asm_vec_c;
  op_e                    req_op_c;

`ifdef HARNESS_DRV_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign tx_hs_c  = tx_valid_q & tx_ready;
  assign rx_hs_c  = rx_valid & rx_ready_q;
  assign req_op_c = op_e'(req_op);

  harness_rsp_assembler #(
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (asm_valid_c),
    .byte_i       (rx_data),
    .clear_i      (asm_clear_c),
    .done_c       (asm_done_c),
    .vec_c        (asm_vec_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    count_d     = count_q;
    req_ready_d = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rx_ready_d  = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    asm_valid_c = 1'b0;
    asm_clear_c = 1'b0;
`ifdef HARNESS_DRV_TIMEOUT_EN
    tmo_d       = '0;
`endif

    // Reply bytes are always drained; outside WAIT_RSP they are protocol errors.
    if (rx_hs_c && (state_q != ST_WAIT_RSP)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          op_d        = req_op_c;
          data_d      = DATA_W'(req_data);
          count_d     = req_count;
          if (req_op_c == OP_STEP) begin
            // A zero count leaves tx idle; STEP then falls straight back to IDLE.
            state_d    = ST_STEP;
            tx_valid_d = (req_count != 16'd0);
            tx_data_d  = CMD_STEP;
          end else begin
            state_d    = ST_SEND_CMD;
            tx_valid_d = 1'b1;
            tx_data_d  = op_to_cmd(req_op_c);
          end
        end
      end

      ST_STEP: begin
        if (count_q == 16'd0) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          tx_valid_d  = 1'b0;
        end else if (tx_hs_c) begin
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            tx_valid_d  = 1'b0;
          end
        end
      end

      ST_SEND_CMD: begin
        if (tx_hs_c) begin
          case (op_q)
            OP_LOAD: begin
              state_d   = ST_SEND_DATA;
              tx_data_d = data_q[DATA_W-1 -: BYTE_W];
              data_d    = data_q << BYTE_W;
              count_d   = 16'(INPUT_BYTES);
            end
            OP_SAMPLE: begin
              state_d    = ST_WAIT_RSP;
              tx_valid_d = 1'b0;
            end
            OP_FINISH: begin
              state_d    = ST_DONE;
              tx_valid_d = 1'b0;
            end
            default: begin
              state_d     = ST_IDLE;
              req_ready_d = 1'b1;
              tx_valid_d  = 1'b0;
            end
          endcase
        end
      end

      // count_q holds payload bytes still owed, including the one on tx_data.
      ST_SEND_DATA: begin
        if (tx_hs_c) begin
          if (count_q == 16'd1) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            tx_valid_d  = 1'b0;
          end else begin
            tx_data_d = data_q[DATA_W-1 -: BYTE_W];
            data_d    = data_q << BYTE_W;
            count_d   = count_q - 16'd1;
          end
        end
      end

      ST_WAIT_RSP: begin
        asm_valid_c = rx_hs_c;
        if (asm_done_c) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = asm_vec_c;
        end
`ifdef HARNESS_DRV_TIMEOUT_EN
        else if (!rx_hs_c) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            err_d       = 1'b1;
            asm_clear_c = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end

      ST_DONE: begin
        req_ready_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RST_ON;
      data_q      <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rx_ready_q  <= rx_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

`ifdef HARNESS_DRV_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rx_ready  = rx_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_harness_cmd_driver.sv
// Directed bench for harness_cmd_driver (INPUT_SIZE=12, OUTPUT_SIZE=40).
// Expected tx bytes and responses are queued when stimulus is issued and
// compared against bytes/responses captured from the DUT.
module tb_harness_cmd_driver;
  import harness_proto_pkg::*;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned OUT_W = 40;
  localparam int unsigned TMO   = 32;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [IN_W-1:0]  req_data;
  logic [15:0]      req_count;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             rsp_valid;
  logic [OUT_W-1:0] rsp_data;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;
  int stab_viol = 0;

  logic [7:0]       exp_tx[$];
  logic [7:0]       obs_tx[$];
  logic [OUT_W-1:0] exp_rsp[$];
  logic [OUT_W-1:0] obs_rsp[$];

  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  harness_cmd_driver #(
    .INPUT_SIZE     (IN_W),
    .OUTPUT_SIZE    (OUT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_count (req_count),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Capture side: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (hold_pend && (tx_valid !== 1'b1 || tx_data !== hold_byte)) stab_viol++;
    hold_pend = (rst === 1'b1 && tx_valid === 1'b1 && tx_ready !== 1'b1);
    hold_byte = tx_data;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) obs_tx.push_back(tx_data);
    if (rsp_valid === 1'b1) obs_rsp.push_back(rsp_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, expv);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_req(input logic [2:0] op, input logic [IN_W-1:0] d, input logic [15:0] c);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin cyc(1); t++; end
    chk("req_ready_before_accept", 64'(req_ready), 64'(1));
    req_op = op; req_data = d; req_count = c; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    chk("req_ready_low_after_accept", 64'(req_ready), 64'(0));
  endtask

  task automatic tx_drain(input string tag);
    int t;
    logic [7:0] e, o;
    t = 0;
    while (obs_tx.size() < exp_tx.size() && t < 500) begin cyc(1); t++; end
    while (exp_tx.size() != 0) begin
      e = exp_tx.pop_front();
      if (obs_tx.size() != 0) o = obs_tx.pop_front();
      else o = 8'hxx;
      chk(tag, 64'(o), 64'(e));
    end
  endtask

  task automatic settle_check(input string tag);
    cyc(3);
    chk(tag, 64'(obs_tx.size()), 64'(0));
  endtask

  task automatic send_rx(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = bytes[8*i +: 8];
      cyc(1);
    end
    rx_valid = 1'b0;
  endtask

  task automatic rsp_check(input string tag);
    int t;
    logic [OUT_W-1:0] e, o;
    t = 0;
    while (obs_rsp.size() == 0 && t < 200) begin cyc(1); t++; end
    e = exp_rsp.pop_front();
    if (obs_rsp.size() != 0) o = obs_rsp.pop_front();
    else o = 'x;
    chk(tag, 64'(o), 64'(e));
    cyc(3);
    chk("rsp_valid_single_pulse", 64'(obs_rsp.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_data = '0; req_count = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    cyc(3);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_tx_valid",  64'(tx_valid),  64'(0));
    chk("rst_tx_data",   64'(tx_data),   64'(0));
    chk("rst_rx_ready",  64'(rx_ready),  64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    chk("rst_err",       64'(err),       64'(0));
    rst = 1'b1;
    cyc(1);
    chk("idle_req_ready", 64'(req_ready), 64'(1));
    chk("idle_rx_ready",  64'(rx_ready),  64'(1));

    // Reset on / off commands
    exp_tx.push_back(8'd106);
    send_req(3'(OP_RST_ON), '0, 16'd0);
    tx_drain("tx_rst_on");
    exp_tx.push_back(8'd107);
    send_req(3'(OP_RST_OFF), '0, 16'd0);
    tx_drain("tx_rst_off");
    settle_check("rst_cmds_no_extra");

    // STEP 3 with back-pressure toggling every cycle
    repeat (3) exp_tx.push_back(8'd108);
    fork
      begin
        repeat (24) begin cyc(1); tx_ready = ~tx_ready; end
        tx_ready = 1'b1;
      end
      begin
        send_req(3'(OP_STEP), '0, 16'd3);
        tx_drain("tx_step3");
      end
    join
    settle_check("step3_no_duplicates");
    chk("tx_hold_stable_step3", 64'(stab_viol), 64'(0));

    // STEP 0: nothing sent, ready again next cycle
    send_req(3'(OP_STEP), '0, 16'd0);
    cyc(1);
    chk("step0_ready_next_cycle", 64'(req_ready), 64'(1));
    settle_check("step0_no_bytes");

    // LOAD 12'hABC: zero-padded, MSB first
    exp_tx.push_back(8'd109);
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'hBC);
    send_req(3'(OP_LOAD), 12'hABC, 16'd0);
    tx_drain("tx_load");
    settle_check("load_no_extra");

    // SAMPLE with an 8-byte reply
    exp_tx.push_back(8'd104);
    exp_rsp.push_back(40'h9A_1234_5678);
    send_req(3'(OP_SAMPLE), '0, 16'd0);
    tx_drain("tx_sample");
    send_rx(64'h0000_009A_1234_5678, 8);
    rsp_check("rsp_sample");
    chk("sample_err_clear", 64'(err), 64'(0));

    // Reset in the middle of a reply, then a fresh sample
    exp_tx.push_back(8'd104);
    send_req(3'(OP_SAMPLE), '0, 16'd0);
    tx_drain("tx_sample_aborted");
    send_rx(64'hDEAD_BEEF_CAFE_F00D, 3);
    rst = 1'b0;
    cyc(1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_no_rsp",    64'(obs_rsp.size()), 64'(0));
    rst = 1'b1;
    cyc(1);
    exp_tx.push_back(8'd104);
    exp_rsp.push_back(40'h55_4433_2211);
    send_req(3'(OP_SAMPLE), '0, 16'd0);
    tx_drain("tx_sample_fresh");
    send_rx(64'h0000_0055_4433_2211, 8);
    rsp_check("rsp_after_reset");
    chk("fresh_err_clear", 64'(err), 64'(0));

`ifdef HARNESS_DRV_TIMEOUT_EN
    // Silent reply: err after the watchdog, no response
    exp_tx.push_back(8'd104);
    send_req(3'(OP_SAMPLE), '0, 16'd0);
    tx_drain("tx_sample_timeout");
    cyc(20);
    chk("timeout_not_early", 64'(err), 64'(0));
    begin
      int t;
      t = 0;
      while (err !== 1'b1 && t < 100) begin cyc(1); t++; end
    end
    chk("timeout_err", 64'(err), 64'(1));
    cyc(1);
    chk("timeout_back_idle", 64'(req_ready), 64'(1));
    chk("timeout_no_rsp", 64'(obs_rsp.size()), 64'(0));
    rst = 1'b0;
    cyc(1);
    chk("timeout_err_reset", 64'(err), 64'(0));
    rst = 1'b1;
    cyc(1);
`endif

    // Stray reply byte while idle: sticky error
    chk("pre_stray_err", 64'(err), 64'(0));
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    cyc(1);
    rx_valid = 1'b0;
    chk("stray_err_set", 64'(err), 64'(1));
    cyc(5);
    chk("stray_err_sticky", 64'(err), 64'(1));
    chk("stray_no_rsp", 64'(obs_rsp.size()), 64'(0));

    // FINISH: driver parks until reset
    exp_tx.push_back(8'd105);
    send_req(3'(OP_FINISH), '0, 16'd0);
    tx_drain("tx_finish");
    req_op = 3'(OP_STEP); req_count = 16'd2; req_valid = 1'b1;
    cyc(6);
    chk("done_req_ready_low", 64'(req_ready), 64'(0));
    req_valid = 1'b0;
    settle_check("done_no_bytes");
    chk("done_err_still_set", 64'(err), 64'(1));
    rst = 1'b0;
    #1;
    chk("done_rst_req_ready", 64'(req_ready), 64'(0));
    chk("done_rst_err", 64'(err), 64'(0));
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("after_done_ready", 64'(req_ready), 64'(1));
    chk("tx_hold_stable", 64'(stab_viol), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
